// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x WIDTH register file with two registered read ports
// and one synchronous write port. Supports optional read-during-write bypass,
// a hardwired zero register, synchronous bulk clear and per-port read-valid.
module regfile_2r1w #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 8,
    parameter int AW          = $clog2(DEPTH),
    parameter int WRITE_FIRST = 1,
    parameter int ZERO_REG    = 0
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Clear,
    input  logic             Write,
    input  logic [AW-1:0]    WAddr,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             REnA,
    input  logic [AW-1:0]    RAddrA,
    output logic [WIDTH-1:0] DataA,
    output logic             ValidA,
    input  logic             REnB,
    input  logic [AW-1:0]    RAddrB,
    output logic [WIDTH-1:0] DataB,
    output logic             ValidB
);

    logic [WIDTH-1:0] regs_q [DEPTH];

    logic [WIDTH-1:0] data_a_q, data_a_d;
    logic [WIDTH-1:0] data_b_q, data_b_d;
    logic             valid_a_q, valid_a_d;
    logic             valid_b_q, valid_b_d;
    logic             wr_accept;

    // Addresses can exceed DEPTH when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < 32'(DEPTH);
    endfunction

    // Register 0 is read-only-zero when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // Value a read port captures on the next edge; earlier rules take priority.
    function automatic logic [WIDTH-1:0] sel_value(input logic [AW-1:0] raddr);
        logic [WIDTH-1:0] v;
        v = '0;
        if (!in_range(raddr) || is_zero_reg(raddr) || Clear) begin
            v = '0;
        end else if ((WRITE_FIRST != 0) && wr_accept && (WAddr == raddr)) begin
            v = WriteData;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (raddr == AW'(i)) v = regs_q[i];
            end
        end
        return v;
    endfunction

    // A write lands only for an existing, writable register.
    assign wr_accept = Write && in_range(WAddr) && !is_zero_reg(WAddr);

    // Read-port next state: data holds when the port is idle, valid follows enable.
    always_comb begin
        data_a_d  = data_a_q;
        data_b_d  = data_b_q;
        valid_a_d = REnA;
        valid_b_d = REnB;
        if (REnA) data_a_d = sel_value(RAddrA);
        if (REnB) data_b_d = sel_value(RAddrB);
    end

    // Register storage: async reset, sync clear overriding any write.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (Clear) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
        end else if (wr_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (WAddr == AW'(i)) regs_q[i] <= WriteData;
            end
        end
    end

    // Registered read outputs for both ports.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    assign DataA  = data_a_q;
    assign DataB  = data_b_q;
    assign ValidA = valid_a_q;
    assign ValidB = valid_b_q;

endmodule
